son3_dout_accum: RTL and testbench

Downstream stage of the SON3 instance. Consumes the 16-bit dout_of_son3 sample stream and sums windows of N = cfg_of_accum+1 samples (N = 1..16). Each completed sum is pushed into a small output FIFO, which drains over a valid/ready handshake to the next consumer. Sticky overflow and FIFO level are exported for status.

---
 rtl/son3_accum_pkg.sv | 17 +
 rtl/son3_accum_fifo.sv | 51 +++++
 rtl/son3_dout_accum.sv | 114 +++++++++++
 tb/tb_son3_dout_accum.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/son3_accum_pkg.sv
// Shared defaults and width helpers for the SON3 output accumulator.
package son3_accum_pkg;

    localparam int DIN_W_DEF = 16;
    localparam int CFG_W_DEF = 4;

    // Sum width: a window of up to 2**cfg_w samples of din_w bits cannot overflow.
    function automatic int out_w(input int din_w, input int cfg_w);
        return din_w + cfg_w;
    endfunction

    // Level counter width: must be able to represent "depth" itself.
    function automatic int level_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/son3_accum_fifo.sv
// Synchronous fall-through FIFO: the head entry is visible on head while not empty.
// The caller only asserts push when there is room (or a pop happens in the same cycle).
module son3_accum_fifo
    import son3_accum_pkg::*;
#(
    parameter  int W     = 20,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = level_w(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic [W-1:0]  head,
    output logic          full,
    output logic          empty,
    output logic [LW-1:0] level
);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         do_pop;

    assign do_pop = pop && !empty;
    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level  = LW'(wr_ptr - rd_ptr);
    assign head   = empty ? '0 : mem[rd_ptr[AW-1:0]];

    // Pointer update; the extra MSB distinguishes full from empty.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push)   wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write; when full with a simultaneous pop, the slot being vacated is reused.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; empty masks stale contents, so no reset fan-out into the array is needed.
        if (push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/son3_dout_accum.sv
// SON3 downstream accumulator: sums windows of cfg_of_accum+1 samples into an output FIFO.
// Optional build macro SON3_ACCUM_DROP_CNT_EN adds a saturating drop_cnt output.
module son3_dout_accum
    import son3_accum_pkg::*;
#(
    parameter  int DIN_W      = DIN_W_DEF,
    parameter  int CFG_W      = CFG_W_DEF,
    parameter  int FIFO_DEPTH = 4,
    localparam int OUT_W      = out_w(DIN_W, CFG_W),
    localparam int LW         = level_w(FIFO_DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CFG_W-1:0] cfg_of_accum,
    input  logic             clr,
    input  logic             din_valid,
    input  logic [DIN_W-1:0] dout_of_son3,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic [OUT_W-1:0] dout_of_accum,
    output logic [LW-1:0]    fifo_level,
    output logic             ovf
`ifdef SON3_ACCUM_DROP_CNT_EN
    ,
    output logic [15:0]      drop_cnt
`endif
);

    logic [OUT_W-1:0] acc;
    logic [CFG_W-1:0] cnt;
    logic [CFG_W-1:0] n_q;
    logic [OUT_W-1:0] din_ext;
    logic [OUT_W-1:0] push_sum;
    logic             push_req;
    logic             accept;
    logic             drop;
    logic             pop;
    logic             full;
    logic             empty;

    assign din_ext    = OUT_W'(dout_of_son3);
    assign dout_valid = !empty;
    assign pop        = dout_valid && dout_ready;
    assign accept     = push_req && (!full || pop);
    assign drop       = push_req && !accept;

    // Detect a completed window and form the sum to be pushed.
    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        push_req = 1'b0;
        push_sum = acc + din_ext;
        if (!clr && din_valid) begin
            if (cnt == '0) begin
                if (cfg_of_accum == '0) begin
                    push_req = 1'b1;
                    push_sum = din_ext;
                end
            end else if (cnt == n_q) begin
                push_req = 1'b1;
            end
        end
    end

    // Window control: accumulate, count samples, latch window length at window start.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
            cnt <= '0;
            n_q <= '0;
            ovf <= 1'b0;
        end else begin
            if (clr) begin
                acc <= '0;
                cnt <= '0;
            end else if (din_valid) begin
                if (cnt == '0) begin
                    acc <= din_ext;
                    n_q <= cfg_of_accum;
                    cnt <= (cfg_of_accum == '0) ? '0 : CFG_W'(1);
                end else if (cnt == n_q) begin
                    cnt <= '0;
                end else begin
                    acc <= acc + din_ext;
                    cnt <= cnt + CFG_W'(1);
                end
            end
            if (drop) ovf <= 1'b1;
        end
    end

`ifdef SON3_ACCUM_DROP_CNT_EN
    // Saturating count of window sums lost to a full FIFO.
    always_ff @(posedge clk) begin
        if (rst)                               drop_cnt <= '0;
        else if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
    end
`endif

    son3_accum_fifo #(
        .W     (OUT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (accept),
        .push_data (push_sum),
        .pop       (pop),
        .head      (dout_of_accum),
        .full      (full),
        .empty     (empty),
        .level     (fifo_level)
    );

endmodule

// File: tb/tb_son3_dout_accum.sv
// Self-checking bench for son3_dout_accum: directed test-plan cases plus random traffic,
// checked against a sample-list/queue reference model and a popped-output scoreboard.
module tb_son3_dout_accum;

    localparam int DIN_W = 16;
    localparam int CFG_W = 4;
    localparam int DEPTH = 4;
    localparam int OUT_W = DIN_W + CFG_W;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst;
    logic [CFG_W-1:0] cfg_of_accum;
    logic             clr;
    logic             din_valid;
    logic [DIN_W-1:0] dout_of_son3;
    logic             dout_valid;
    logic             dout_ready;
    logic [OUT_W-1:0] dout_of_accum;
    logic [LW-1:0]    fifo_level;
    logic             ovf;
`ifdef SON3_ACCUM_DROP_CNT_EN
    logic [15:0]      drop_cnt;
`endif

    int vectors = 0;
    int fails   = 0;

    // Reference model state
    int unsigned win_q[$];   // samples of the window in progress
    int unsigned win_len;    // length fixed when the window's first sample arrives
    int unsigned fifo_m[$];  // expected FIFO contents after each edge
    int unsigned exp_q[$];   // scoreboard: sums the consumer should receive, in order
    bit          ovf_m;
    int unsigned drops_m;

    son3_dout_accum #(.DIN_W(DIN_W), .CFG_W(CFG_W), .FIFO_DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .cfg_of_accum  (cfg_of_accum),
        .clr           (clr),
        .din_valid     (din_valid),
        .dout_of_son3  (dout_of_son3),
        .dout_valid    (dout_valid),
        .dout_ready    (dout_ready),
        .dout_of_accum (dout_of_accum),
        .fifo_level    (fifo_level),
        .ovf           (ovf)
`ifdef SON3_ACCUM_DROP_CNT_EN
        ,
        .drop_cnt      (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply one cycle of stimulus, advance the model across the coming edge, then check status.
    task automatic cycle(input bit r, input bit v, input int unsigned d, input int unsigned c,
                         input bit cl, input bit rd);
        bit          pop_m;
        bit          done;
        int unsigned sum;
        rst          = r;
        din_valid    = v;
        dout_of_son3 = DIN_W'(d);
        cfg_of_accum = CFG_W'(c);
        clr          = cl;
        dout_ready   = rd;

        done = 0;
        sum  = 0;
        if (r) begin
            win_q.delete();
            fifo_m.delete();
            exp_q.delete();
            ovf_m   = 0;
            drops_m = 0;
        end else begin
            pop_m = (fifo_m.size() > 0) && rd;
            if (cl) begin
                win_q.delete();
            end else if (v) begin
                if (win_q.size() == 0) win_len = (c % 16) + 1;
                win_q.push_back(d % 65536);
                if (win_q.size() == win_len) begin
                    foreach (win_q[i]) sum += win_q[i];
                    win_q.delete();
                    done = 1;
                end
            end
            if (pop_m) void'(fifo_m.pop_front());
            if (done) begin
                if (fifo_m.size() < DEPTH) begin
                    fifo_m.push_back(sum);
                    exp_q.push_back(sum);
                end else begin
                    ovf_m = 1;
                    if (drops_m < 16'hFFFF) drops_m++;
                end
            end
        end

        @(posedge clk);
        #1;
        check("fifo_level", 32'(fifo_level), fifo_m.size());
        check("dout_valid", 32'(dout_valid), 32'(fifo_m.size() > 0));
        check("ovf", 32'(ovf), 32'(ovf_m));
        check("head", 32'(dout_of_accum), (fifo_m.size() > 0) ? fifo_m[0] : 0);
`ifdef SON3_ACCUM_DROP_CNT_EN
        check("drop_cnt", 32'(drop_cnt), drops_m);
`endif
    endtask

    task automatic idle(input int n, input bit rd);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, rd);
    endtask

    // Monitor: a pop will happen at the next edge; the value must match the scoreboard head.
    always @(negedge clk) begin
        if (rst === 1'b0 && dout_valid === 1'b1 && dout_ready === 1'b1) begin
            if (exp_q.size() == 0) check("unexpected_pop", 32'(dout_of_accum), 32'hDEAD_BEEF);
            else                   check("pop_data", 32'(dout_of_accum), exp_q.pop_front());
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, actual running required finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned rcfg;
        cycle(1, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0);

        // Window of 4: 1+2+3+4 appears one cycle after the fourth sample
        for (int i = 1; i <= 4; i++) cycle(0, 1, i, 3, 0, 1);
        check("t1_valid", 32'(dout_valid), 1);
        check("t1_sum", 32'(dout_of_accum), 10);
        idle(2, 1);

        // Largest window of all-ones samples, then a single-sample window
        for (int i = 0; i < 16; i++) cycle(0, 1, 16'hFFFF, 15, 0, 1);
        check("t2_max_sum", 32'(dout_of_accum), 32'hFFFF0);
        cycle(0, 1, 16'hFFFF, 0, 0, 1);
        check("t2_n1_sum", 32'(dout_of_accum), 32'h0FFFF);
        idle(2, 1);

        // Overflow: six N=1 windows into a stalled 4-entry FIFO
        for (int i = 1; i <= 6; i++) cycle(0, 1, i, 0, 0, 0);
        check("t3_level", 32'(fifo_level), 4);
        check("t3_ovf", 32'(ovf), 1);
`ifdef SON3_ACCUM_DROP_CNT_EN
        check("t3_drop_cnt", 32'(drop_cnt), 2);
`endif
        idle(6, 1);
        cycle(1, 0, 0, 0, 0, 0);

        // Config change mid-window applies from the next window
        cycle(0, 1, 5, 3, 0, 1);
        cycle(0, 1, 5, 3, 0, 1);
        cycle(0, 1, 5, 1, 0, 1);
        cycle(0, 1, 5, 1, 0, 1);
        check("t4_sum20", 32'(dout_of_accum), 20);
        cycle(0, 1, 7, 1, 0, 1);
        cycle(0, 1, 7, 1, 0, 1);
        check("t4_sum14", 32'(dout_of_accum), 14);
        idle(2, 1);

        // clr discards a partial window
        cycle(0, 1, 9, 3, 0, 1);
        cycle(0, 1, 9, 3, 0, 1);
        cycle(0, 1, 9, 3, 1, 1);
        for (int i = 0; i < 4; i++) cycle(0, 1, 1, 3, 0, 1);
        check("t5_clr_sum", 32'(dout_of_accum), 4);
        idle(2, 1);

        // rst discards a partial window
        cycle(0, 1, 9, 3, 0, 1);
        cycle(0, 1, 9, 3, 0, 1);
        cycle(1, 0, 0, 3, 0, 0);
        for (int i = 0; i < 4; i++) cycle(0, 1, 1, 3, 0, 1);
        check("t5_rst_sum", 32'(dout_of_accum), 4);
        idle(2, 1);

        // Full FIFO with a pop in the same cycle as a push: accepted, level stays at 4
        cycle(1, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 4; i++) cycle(0, 1, i * 11, 0, 0, 0);
        cycle(0, 1, 77, 0, 0, 1);
        check("t6_level", 32'(fifo_level), 4);
        check("t6_ovf", 32'(ovf), 0);
        idle(6, 1);

        // Random traffic
        rcfg = 3;
        for (int i = 0; i < 3000; i++) begin
            int unsigned d;
            if ($urandom_range(0, 19) == 0) rcfg = $urandom_range(0, 15);
            d = ($urandom_range(0, 3) == 0) ? 16'hFFFF : $urandom_range(0, 65535);
            cycle($urandom_range(0, 999) < 3, $urandom_range(0, 3) != 0, d, rcfg,
                  $urandom_range(0, 49) == 0, $urandom_range(0, 9) < 6);
        end

        idle(8, 1);
        check("drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
